// File: rtl/stage_decode_pipe.sv
// Decode stage with a registered F/D -> D/X boundary, register-read address decode and flush.
// Define LOAD_USE_INTERLOCK_EN to add the load-use scoreboard and interlock (HAZ_DEPTH deep).
module stage_decode_pipe #(
  parameter int unsigned HAZ_DEPTH = 1,
  parameter logic [4:0]  BEX_REG   = 5'd30,
  parameter logic [4:0]  LW_OPC    = 5'b01000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fd_valid,
  input  logic [31:0] fd_insn,
  input  logic [31:0] fd_pc,
  output logic        fd_ready,
  input  logic        flush,
  output logic [4:0]  ctrl_readRegA,
  output logic [4:0]  ctrl_readRegB,
  output logic        dx_valid,
  input  logic        dx_ready,
  output logic [31:0] dx_insn,
  output logic [31:0] dx_pc,
  output logic        stall
);

  localparam logic [4:0] OPC_R    = 5'b00000;
  localparam logic [4:0] OPC_J    = 5'b00001;
  localparam logic [4:0] OPC_BNE  = 5'b00010;
  localparam logic [4:0] OPC_JAL  = 5'b00011;
  localparam logic [4:0] OPC_JR   = 5'b00100;
  localparam logic [4:0] OPC_BLT  = 5'b00110;
  localparam logic [4:0] OPC_SW   = 5'b00111;
  localparam logic [4:0] OPC_SETX = 5'b10101;
  localparam logic [4:0] OPC_BEX  = 5'b10110;

  logic [4:0]  fd_opc, fd_rd, fd_rs, fd_rt;
  logic        r_insn, bex_insn, src_a_used, src_b_used;
  logic        hazard, advance, accept;
  logic        sb0_vld;
  logic [4:0]  sb0_dst;
  logic        dx_valid_q, dx_valid_d;
  logic [31:0] dx_insn_q, dx_insn_d;
  logic [31:0] dx_pc_q, dx_pc_d;

  function automatic logic src_hit(input logic vld, input logic [4:0] dst,
                                   input logic a_used, input logic [4:0] a,
                                   input logic b_used, input logic [4:0] b);
    return vld && (dst != 5'd0) && ((a_used && (dst == a)) || (b_used && (dst == b)));
  endfunction

  assign fd_opc = fd_insn[31:27];
  assign fd_rd  = fd_insn[26:22];
  assign fd_rs  = fd_insn[21:17];
  assign fd_rt  = fd_insn[16:12];

  // F/D side: read addresses decode from the raw word, valid or not
  always_comb begin
    r_insn        = (fd_opc == OPC_R);
    bex_insn      = (fd_opc == OPC_BEX);
    ctrl_readRegA = bex_insn ? BEX_REG : fd_rs;
    ctrl_readRegB = r_insn ? fd_rt : fd_rd;
    src_a_used    = !((fd_opc == OPC_J) || (fd_opc == OPC_JAL) || (fd_opc == OPC_SETX));
    src_b_used    = r_insn || (fd_opc == OPC_SW) || (fd_opc == OPC_BNE) ||
                    (fd_opc == OPC_BLT) || (fd_opc == OPC_JR);
  end

  // The D/X register itself is scoreboard entry 0
  assign sb0_vld = dx_valid_q && (dx_insn_q[31:27] == LW_OPC);
  assign sb0_dst = dx_insn_q[26:22];

`ifdef LOAD_USE_INTERLOCK_EN
  logic tail_hit;

  if (HAZ_DEPTH > 1) begin : g_sb_tail
    localparam int N = int'(HAZ_DEPTH) - 1;
    logic [N-1:0] vld_q, vld_d;
    logic [4:0]   dst_q [N];
    logic [4:0]   dst_d [N];

    // Loads that already left D/X; advances only when execute consumes D/X
    always_comb begin
      vld_d = vld_q;
      dst_d = dst_q;
      if (dx_ready) begin
        vld_d[0] = sb0_vld;
        dst_d[0] = sb0_dst;
        for (int k = 1; k < N; k++) begin
          vld_d[k] = vld_q[k-1];
          dst_d[k] = dst_q[k-1];
        end
      end
    end

    always_comb begin
      tail_hit = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (src_hit(vld_q[k], dst_q[k], src_a_used, ctrl_readRegA, src_b_used, ctrl_readRegB))
          tail_hit = 1'b1;
      end
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        vld_q <= '0;
        for (int k = 0; k < N; k++) dst_q[k] <= 5'd0;
      end else begin
        vld_q <= vld_d;
        dst_q <= dst_d;
      end
    end
  end else begin : g_sb_none
    assign tail_hit = 1'b0;
  end

  assign hazard = fd_valid && !flush &&
                  (src_hit(sb0_vld, sb0_dst, src_a_used, ctrl_readRegA, src_b_used, ctrl_readRegB)
                   || tail_hit);
`else
  logic unused_interlock;
  assign unused_interlock = ^{src_a_used, src_b_used, sb0_vld, sb0_dst, HAZ_DEPTH[0]};
  assign hazard = 1'b0;
`endif

  assign advance  = dx_ready || !dx_valid_q;
  assign accept   = advance && !hazard;
  assign fd_ready = flush || accept;
  assign stall    = hazard && advance;

  // D/X boundary: flush beats accept beats bubble beats hold
  always_comb begin
    dx_valid_d = dx_valid_q;
    dx_insn_d  = dx_insn_q;
    dx_pc_d    = dx_pc_q;
    if (flush) begin
      dx_valid_d = 1'b0;
    end else if (accept) begin
      dx_valid_d = fd_valid;
      dx_insn_d  = fd_insn;
      dx_pc_d    = fd_pc;
    end else if (advance) begin
      dx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dx_valid_q <= 1'b0;
      dx_insn_q  <= 32'd0;
      dx_pc_q    <= 32'd0;
    end else begin
      dx_valid_q <= dx_valid_d;
      dx_insn_q  <= dx_insn_d;
      dx_pc_q    <= dx_pc_d;
    end
  end

  assign dx_valid = dx_valid_q;
  assign dx_insn  = dx_insn_q;
  assign dx_pc    = dx_pc_q;

endmodule

// File: tb/tb_stage_decode_pipe.sv
// Directed bench for stage_decode_pipe: vector table on a HAZ_DEPTH=1 instance plus
// hand sequences for stall, backpressure, flush, reset and a HAZ_DEPTH=2 instance.
module tb_stage_decode_pipe;

`ifdef LOAD_USE_INTERLOCK_EN
  localparam bit IL = 1'b1;
`else
  localparam bit IL = 1'b0;
`endif

  localparam logic [31:0] ADD123 = {5'd0, 5'd1, 5'd2, 5'd3, 12'd0};
  localparam logic [31:0] BEX7   = {5'b10110, 5'd0, 5'd7, 5'd0, 12'd0};
  localparam logic [31:0] SW56   = {5'b00111, 5'd5, 5'd6, 5'd0, 12'd0};
  localparam logic [31:0] ADD9   = {5'd0, 5'd9, 5'd10, 5'd11, 12'd0};
  localparam logic [31:0] LW4    = {5'b01000, 5'd4, 5'd1, 5'd0, 12'd0};
  localparam logic [31:0] ADD789 = {5'd0, 5'd7, 5'd8, 5'd9, 12'd0};
  localparam logic [31:0] LW5    = {5'b01000, 5'd5, 5'd2, 5'd0, 12'd0};
  localparam logic [31:0] J55    = {5'b00001, 5'd5, 5'd5, 5'd0, 12'd0};
  localparam logic [31:0] LW0    = {5'b01000, 5'd0, 5'd3, 5'd0, 12'd0};
  localparam logic [31:0] ADD602 = {5'd0, 5'd6, 5'd0, 5'd2, 12'd0};
  localparam logic [31:0] ADD642 = {5'd0, 5'd6, 5'd4, 5'd2, 12'd0};

  typedef struct {
    string       name;
    bit          fv;
    logic [31:0] insn;
    logic [31:0] pc;
    bit          fl;
    bit          dxr;
    logic [4:0]  ea;
    logic [4:0]  eb;
    bit          erdy;
    bit          estall;
    bit          edv;
    bit          cdx;
    logic [31:0] einsn;
    logic [31:0] epc;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        fd_valid = 1'b0, flush = 1'b0, dx_ready = 1'b1;
  logic [31:0] fd_insn = 32'd0, fd_pc = 32'd0;
  logic        fd_ready, dx_valid, stall;
  logic [4:0]  rd_a, rd_b;
  logic [31:0] dx_insn, dx_pc;

  logic        fv2 = 1'b0, fl2 = 1'b0, dxr2 = 1'b1;
  logic [31:0] insn2 = 32'd0, pc2 = 32'd0;
  logic        fd_ready2, dx_valid2, stall2;
  logic [4:0]  rd_a2, rd_b2;
  logic [31:0] dx_insn2, dx_pc2;

  int checks = 0;
  int errors = 0;
  vec_t tbl[11];

  always #5 clock = ~clock;

  stage_decode_pipe #(.HAZ_DEPTH(1)) u_dut (
    .clock(clock), .reset_n(reset_n), .fd_valid(fd_valid), .fd_insn(fd_insn), .fd_pc(fd_pc),
    .fd_ready(fd_ready), .flush(flush), .ctrl_readRegA(rd_a), .ctrl_readRegB(rd_b),
    .dx_valid(dx_valid), .dx_ready(dx_ready), .dx_insn(dx_insn), .dx_pc(dx_pc), .stall(stall)
  );

  stage_decode_pipe #(.HAZ_DEPTH(2)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .fd_valid(fv2), .fd_insn(insn2), .fd_pc(pc2),
    .fd_ready(fd_ready2), .flush(fl2), .ctrl_readRegA(rd_a2), .ctrl_readRegB(rd_b2),
    .dx_valid(dx_valid2), .dx_ready(dxr2), .dx_insn(dx_insn2), .dx_pc(dx_pc2), .stall(stall2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input bit fv, input logic [31:0] insn,
                              input logic [31:0] pc, input bit fl, input bit dxr,
                              input logic [4:0] ea, input logic [4:0] eb, input bit erdy,
                              input bit estall, input bit edv, input bit cdx,
                              input logic [31:0] einsn, input logic [31:0] epc);
    vec_t v;
    v.name = nm; v.fv = fv; v.insn = insn; v.pc = pc; v.fl = fl; v.dxr = dxr;
    v.ea = ea; v.eb = eb; v.erdy = erdy; v.estall = estall; v.edv = edv;
    v.cdx = cdx; v.einsn = einsn; v.epc = epc;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    @(negedge clock);
    fd_valid = v.fv; fd_insn = v.insn; fd_pc = v.pc; flush = v.fl; dx_ready = v.dxr;
    #1;
    chk({v.name, ".readRegA"}, {27'd0, rd_a}, {27'd0, v.ea});
    chk({v.name, ".readRegB"}, {27'd0, rd_b}, {27'd0, v.eb});
    chk({v.name, ".fd_ready"}, {31'd0, fd_ready}, {31'd0, v.erdy});
    chk({v.name, ".stall"}, {31'd0, stall}, {31'd0, v.estall});
    @(posedge clock);
    #1;
    chk({v.name, ".dx_valid"}, {31'd0, dx_valid}, {31'd0, v.edv});
    if (v.cdx) begin
      chk({v.name, ".dx_insn"}, dx_insn, v.einsn);
      chk({v.name, ".dx_pc"}, dx_pc, v.epc);
    end
  endtask

  task automatic run_dep2(input string nm, input bit with_mid, input int exp_bubbles);
    int  bubbles = 0;
    bit  done = 1'b0;
    @(negedge clock);
    fv2 = 1'b1; insn2 = LW4; pc2 = 32'h600;
    if (with_mid) begin
      @(negedge clock);
      insn2 = ADD789; pc2 = 32'h604;
    end
    @(negedge clock);
    insn2 = ADD642; pc2 = 32'h608;
    for (int c = 0; c < 10 && !done; c++) begin
      #1;
      if (fd_ready2) done = 1'b1;
      else if (stall2) bubbles++;
      @(posedge clock);
      if (!done) @(negedge clock);
    end
    #1;
    chk({nm, ".accepted"}, {31'd0, done}, 32'd1);
    chk({nm, ".bubbles"}, bubbles, exp_bubbles);
    chk({nm, ".dx_valid"}, {31'd0, dx_valid2}, 32'd1);
    chk({nm, ".dx_insn"}, dx_insn2, ADD642);
    @(negedge clock);
    fv2 = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk("add123", 1, ADD123, 32'h100, 0, 1, 5'd2,  5'd3,  1, 0, 1, 1, ADD123, 32'h100);
    tbl[1]  = mk("bex7",   1, BEX7,   32'h104, 0, 1, 5'd30, 5'd0,  1, 0, 1, 1, BEX7,   32'h104);
    tbl[2]  = mk("sw56",   1, SW56,   32'h108, 0, 1, 5'd6,  5'd5,  1, 0, 1, 1, SW56,   32'h108);
    tbl[3]  = mk("idle",   0, ADD9,   32'h10C, 0, 1, 5'd10, 5'd11, 1, 0, 0, 0, 32'd0,  32'd0);
    tbl[4]  = mk("lw4",    1, LW4,    32'h110, 0, 1, 5'd1,  5'd4,  1, 0, 1, 1, LW4,    32'h110);
    tbl[5]  = mk("indep",  1, ADD789, 32'h114, 0, 1, 5'd8,  5'd9,  1, 0, 1, 1, ADD789, 32'h114);
    tbl[6]  = mk("lw5",    1, LW5,    32'h118, 0, 1, 5'd2,  5'd5,  1, 0, 1, 1, LW5,    32'h118);
    tbl[7]  = mk("j_nosrc",1, J55,    32'h11C, 0, 1, 5'd5,  5'd5,  1, 0, 1, 1, J55,    32'h11C);
    tbl[8]  = mk("lw0",    1, LW0,    32'h120, 0, 1, 5'd3,  5'd0,  1, 0, 1, 1, LW0,    32'h120);
    tbl[9]  = mk("use_r0", 1, ADD602, 32'h124, 0, 1, 5'd0,  5'd2,  1, 0, 1, 1, ADD602, 32'h124);
    tbl[10] = mk("flush",  1, ADD123, 32'h128, 1, 1, 5'd2,  5'd3,  1, 0, 0, 0, 32'd0,  32'd0);

    // Reset state, address decode live while in reset
    fd_insn = ADD123;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.dx_valid", {31'd0, dx_valid}, 32'd0);
    chk("rst.dx_insn", dx_insn, 32'd0);
    chk("rst.dx_pc", dx_pc, 32'd0);
    chk("rst.fd_ready", {31'd0, fd_ready}, 32'd1);
    chk("rst.stall", {31'd0, stall}, 32'd0);
    chk("rst.readRegA", {27'd0, rd_a}, 32'd2);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) apply(tbl[i]);

    // Load-use on a HAZ_DEPTH=1 instance
    apply(mk("lu_lw", 1, LW4, 32'h200, 0, 1, 5'd1, 5'd4, 1, 0, 1, 1, LW4, 32'h200));
`ifdef LOAD_USE_INTERLOCK_EN
    apply(mk("lu_stall", 1, ADD642, 32'h204, 0, 1, 5'd4, 5'd2, 0, 1, 0, 0, 32'd0, 32'd0));
`endif
    apply(mk("lu_go", 1, ADD642, 32'h204, 0, 1, 5'd4, 5'd2, 1, 0, 1, 1, ADD642, 32'h204));

    // Execute backpressure for three cycles, then release
    apply(mk("bp_load", 1, ADD123, 32'h300, 0, 1, 5'd2, 5'd3, 1, 0, 1, 1, ADD123, 32'h300));
    for (int i = 0; i < 3; i++)
      apply(mk("bp_hold", 1, SW56, 32'h304, 0, 0, 5'd6, 5'd5, 0, 0, 1, 1, ADD123, 32'h300));
    apply(mk("bp_release", 1, SW56, 32'h304, 0, 1, 5'd6, 5'd5, 1, 0, 1, 1, SW56, 32'h304));

    // Flush arriving in a load-use stall cycle
    apply(mk("fl_lw", 1, LW4, 32'h400, 0, 1, 5'd1, 5'd4, 1, 0, 1, 1, LW4, 32'h400));
    @(negedge clock);
    fd_valid = 1'b1; fd_insn = ADD642; fd_pc = 32'h404; flush = 1'b0; dx_ready = 1'b1;
    #1;
    chk("fl_pre.stall", {31'd0, stall}, {31'd0, IL});
    chk("fl_pre.fd_ready", {31'd0, fd_ready}, {31'd0, !IL});
    flush = 1'b1;
    #1;
    chk("fl.stall", {31'd0, stall}, 32'd0);
    chk("fl.fd_ready", {31'd0, fd_ready}, 32'd1);
    @(posedge clock);
    #1;
    chk("fl.dx_valid", {31'd0, dx_valid}, 32'd0);
    flush = 1'b0;

    // Asynchronous reset in the middle of a stall
    apply(mk("rs_lw", 1, LW4, 32'h500, 0, 1, 5'd1, 5'd4, 1, 0, 1, 1, LW4, 32'h500));
    @(negedge clock);
    fd_insn = ADD642; fd_pc = 32'h504;
    #1;
    chk("rs_pre.stall", {31'd0, stall}, {31'd0, IL});
    reset_n = 1'b0;
    #1;
    chk("rs.dx_valid", {31'd0, dx_valid}, 32'd0);
    chk("rs.dx_insn", dx_insn, 32'd0);
    chk("rs.fd_ready", {31'd0, fd_ready}, 32'd1);
    chk("rs.stall", {31'd0, stall}, 32'd0);
    fd_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    // HAZ_DEPTH=2: one independent instruction hides one bubble
    run_dep2("hd2_mid", 1'b1, IL ? 1 : 0);
    run_dep2("hd2_back", 1'b0, IL ? 2 : 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
